// File: rtl/sd_dma_sink.sv
// sd_dma_sink: Wishbone classic slave that buffers SD DMA words and unpacks them
// into a byte stream, throttling the master via ack and flagging each completed block.
module sd_dma_sink #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int BLOCK_BYTES_LOG2 = 9
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic [31:0]                wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  input  logic [3:0]                 wb_sel_i,
  input  logic                       wb_we_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic [2:0]                 wb_cti_i,
  input  logic [1:0]                 wb_bte_i,
  output logic                       wb_ack_o,
  output logic [31:0]                wb_dat_o,
  output logic [7:0]                 byte_data,
  output logic                       byte_valid,
  input  logic                       byte_ready,
  output logic                       block_done,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       bus_err
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LW = FIFO_DEPTH_LOG2 + 1;
  logic [31:0] mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [31:0] hold;
  logic [1:0] idx;
  logic hold_valid;
  logic [BLOCK_BYTES_LOG2-1:0] cnt;
  logic req, sel_ok, full, empty, good, bad, pop, hs, last;
  logic unused;
  assign unused = ^{wb_adr_i, wb_cti_i, wb_bte_i};
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign sel_ok = wb_sel_i == 4'hF;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign good = req & wb_we_i & sel_ok & ~full;
  assign bad = req & (~wb_we_i | ~sel_ok);
  assign hs = hold_valid & byte_ready;
  assign last = hs & (idx == 2'd3);
  // Reload on the final byte's handshake so a non-empty FIFO streams without a bubble
  assign pop = (~hold_valid | last) & ~empty;
  assign wb_dat_o = '0;
  assign byte_valid = hold_valid;
  assign fifo_level = level;
  assign byte_data = idx == 2'd0 ? hold[31:24] : idx == 2'd1 ? hold[23:16] :
                     idx == 2'd2 ? hold[15:8] : hold[7:0];
  always_ff @(posedge clk)
    if (good & ~clear) mem[wr_ptr] <= wb_dat_i;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      hold <= '0;
      idx <= '0;
      hold_valid <= 1'b0;
      cnt <= '0;
      block_done <= 1'b0;
      bus_err <= 1'b0;
    end else if (clear) begin
      wb_ack_o <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      hold <= '0;
      idx <= '0;
      hold_valid <= 1'b0;
      cnt <= '0;
      block_done <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      wb_ack_o <= good | bad;
      if (good) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(good) - LW'(pop);
      if (pop) begin
        hold <= mem[rd_ptr];
        idx <= '0;
        hold_valid <= 1'b1;
      end else if (hs) begin
        idx <= idx + 1'b1;
        if (last) hold_valid <= 1'b0;
      end
      if (hs) cnt <= cnt + 1'b1;
      block_done <= hs & (&cnt);
      if (bad) bus_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sd_dma_sink.sv
// tb_sd_dma_sink: randomized self-checking bench; expected bytes come from a queue
// of written words and block pulses from a running byte count modulo the block size.
module tb_sd_dma_sink;
  logic clk = 0, reset_n = 0, clear = 0;
  logic [31:0] wb_adr_i = 0, wb_dat_i = 0, wb_dat_o;
  logic [3:0] wb_sel_i = 0;
  logic wb_we_i = 0, wb_cyc_i = 0, wb_stb_i = 0, wb_ack_o;
  logic [2:0] wb_cti_i = 0;
  logic [1:0] wb_bte_i = 0;
  logic [7:0] byte_data;
  logic byte_valid, byte_ready = 0, block_done, bus_err;
  logic [4:0] fifo_level;
  int n_err = 0, n_chk = 0, pulses = 0, cnt = 0, ready_mode = 0, w = 0;
  bit bd_exp = 0, prev_ack = 0;
  logic [7:0] q[$];

  sd_dma_sink dut (.clk(clk), .reset_n(reset_n), .clear(clear), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_ack_o(wb_ack_o),
    .wb_dat_o(wb_dat_o), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .block_done(block_done), .fifo_level(fifo_level),
    .bus_err(bus_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    byte_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
  end

  // Stream monitor: bytes must leave in write order; a block pulse follows every 512th byte
  always @(negedge clk) begin
    if (!reset_n || clear) begin
      bd_exp = 0;
      cnt = 0;
      prev_ack = 0;
    end else begin
      if (prev_ack) chk("ack_width", wb_ack_o, 0);
      prev_ack = wb_ack_o;
      if (bd_exp || block_done) chk("block_done", block_done, bd_exp);
      if (block_done) pulses++;
      bd_exp = 0;
      if (byte_valid && byte_ready) begin
        if (q.size() == 0) chk("spurious_byte", {24'd0, byte_data}, 32'hFFFF_FFFF);
        else chk("byte", byte_data, q.pop_front());
        cnt = (cnt + 1) % 512;
        if (cnt == 0) bd_exp = 1;
      end
    end
  end

  task automatic push_word(input logic [31:0] d);
    q.push_back(d[31:24]); q.push_back(d[23:16]); q.push_back(d[15:8]); q.push_back(d[7:0]);
  endtask

  task automatic wb_write(input logic [31:0] d, input logic [3:0] sel, input logic we,
                          output int waits);
    waits = 0;
    wb_dat_i = d; wb_sel_i = sel; wb_we_i = we; wb_adr_i = $urandom;
    wb_cti_i = 3'($urandom); wb_bte_i = 2'($urandom);
    wb_cyc_i = 1; wb_stb_i = 1;
    forever begin
      @(negedge clk);
      waits++;
      if (wb_ack_o) begin
        chk("dat_o", wb_dat_o, 0);
        if (we && sel == 4'hF) push_word(d);
        break;
      end
      if (waits >= 300) begin
        chk("ack_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (q.size() != 0 && c < maxc) begin @(negedge clk); c++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1;
    q.delete();
    @(posedge clk); #1;
    clear = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, wb_ack_o, 0);
    chk({tag, "_dat_o"}, wb_dat_o, 0);
    chk({tag, "_valid"}, byte_valid, 0);
    chk({tag, "_data"}, byte_data, 0);
    chk({tag, "_done"}, block_done, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_err"}, bus_err, 0);
  endtask

  initial begin
    int acks;
    #2;
    chk_idle_outputs("reset");
    idle(2);
    reset_n = 1;
    ready_mode = 1;
    idle(2);
    // single word: ack one cycle after stb, first byte one cycle later
    wb_write(32'hA1B2C3D4, 4'hF, 1, w);
    chk("single_ack_lat", w, 2);
    @(negedge clk);
    chk("single_ack_low", wb_ack_o, 0);
    chk("single_b0_valid", byte_valid, 1);
    chk("single_b0", byte_data, 8'hA1);
    @(negedge clk); chk("single_b1", byte_data, 8'hB2);
    @(negedge clk); chk("single_b2", byte_data, 8'hC3);
    @(negedge clk); chk("single_b3", byte_data, 8'hD4);
    @(negedge clk);
    chk("single_empty_valid", byte_valid, 0);
    chk("single_level", fifo_level, 0);
    idle(1);
    // backpressure: holder plus 16 FIFO words, then the next write waits
    ready_mode = 0;
    idle(2);
    for (int i = 0; i < 17; i++) wb_write(32'h1000_0000 + i * 32'h0101_0101, 4'hF, 1, w);
    chk("bp_level_full", fifo_level, 16);
    chk("bp_holder_valid", byte_valid, 1);
    wb_dat_i = 32'hCAFE_0018; wb_sel_i = 4'hF; wb_we_i = 1; wb_cyc_i = 1; wb_stb_i = 1;
    acks = 0;
    repeat (10) begin @(negedge clk); if (wb_ack_o) acks++; end
    chk("bp_held_no_ack", acks, 0);
    chk("bp_held_level", fifo_level, 16);
    ready_mode = 1;
    w = 0;
    while (!wb_ack_o && w < 100) begin @(negedge clk); w++; end
    chk("bp_resume_ack", wb_ack_o, 1);
    push_word(32'hCAFE_0018);
    @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0;
    wb_write(32'hCAFE_0019, 4'hF, 1, w);
    wb_write(32'hCAFE_0020, 4'hF, 1, w);
    drain(400);
    idle(2);
    chk("bp_level_end", fifo_level, 0);
    // illegal accesses
    wb_write(32'hDEAD_BEEF, 4'hF, 0, w);
    chk("read_ack_lat", w, 2);
    chk("read_err", bus_err, 1);
    wb_write(32'h5555_AAAA, 4'h3, 1, w);
    chk("partial_ack_lat", w, 2);
    idle(4);
    chk("illegal_err", bus_err, 1);
    chk("illegal_no_bytes", byte_valid, 0);
    chk("illegal_level", fifo_level, 0);
    do_clear();
    chk("clear_err", bus_err, 0);
    // full blocks with random consumer
    pulses = 0;
    ready_mode = 2;
    for (int i = 0; i < 256; i++) begin
      wb_write(i, 4'hF, 1, w);
      idle($urandom_range(0, 2));
    end
    drain(3000);
    idle(3);
    chk("block_pulses", pulses, 2);
    // reset mid-stream
    ready_mode = 0;
    idle(2);
    for (int i = 0; i < 6; i++) wb_write(32'h7700_0000 + i, 4'hF, 1, w);
    reset_n = 0;
    q.delete();
    #1;
    chk_idle_outputs("midreset");
    @(posedge clk); #1;
    reset_n = 1;
    ready_mode = 1;
    idle(2);
    wb_write(32'h01020304, 4'hF, 1, w);
    chk("post_reset_ack_lat", w, 2);
    drain(20);
    idle(2);
    chk("post_reset_valid", byte_valid, 0);
    chk("post_reset_level", fifo_level, 0);
    // clear mid-stream
    ready_mode = 0;
    idle(2);
    for (int i = 0; i < 6; i++) wb_write(32'h6600_0000 + i, 4'hF, 1, w);
    chk("pre_clear_level", fifo_level, 5);
    do_clear();
    chk_idle_outputs("midclear");
    ready_mode = 1;
    idle(2);
    wb_write(32'h01020304, 4'hF, 1, w);
    drain(20);
    idle(2);
    chk("post_clear_valid", byte_valid, 0);
    chk("post_clear_level", fifo_level, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
